grf_scoreboard: RTL and testbench
=================================

// Module: grf_scoreboard
// PURPOSE
//  Next-generation general register file for the pipelined CPU.
//  - Parametrised width, depth and read-port count; two write ports.
//  - Same-cycle write-to-read bypass on every read port.
//  - Per-register pending-writer scoreboard: decode reserves the destination, writeback releases it.
//  - Hazard logic reads pending flags directly instead of re-deriving them from pipeline stages.
// PARAMETERS
//  DW      32  data width in bits
//  NREG    32  number of registers; register 0 is hardwired to zero
//  AW      5   address width, clog2(NREG)
//  NRD     3   number of combinational read ports
//  CNT_W   2   pending-counter width; max outstanding writers per register = 2**CNT_W-1
//  TRACE   1   1 = emit write trace via $display
// PORTS
//  clk        in   1        clock, all state updates on posedge
//  reset      in   1        synchronous, active-high; clears all state
//  rd_addr    in   NRD*AW   read addresses, port k at [k*AW +: AW]
//  rd_data    out  NRD*DW   read data, port k at [k*DW +: DW]
//  rd_pend    out  NRD      1 = register still has outstanding writers after this cycle's releases
//  wr0_en     in   1        write port 0 enable (older instruction)
//  wr0_addr   in   AW       write port 0 address
//  wr0_data   in   DW       write port 0 data
//  wr0_pc     in   32       PC of the writing instruction, trace only
//  wr1_en     in   1        write port 1 enable (younger instruction)
//  wr1_addr   in   AW       write port 1 address
//  wr1_data   in   DW       write port 1 data
//  wr1_pc     in   32       PC of the writing instruction, trace only
//  rsv_en     in   1        reserve rsv_addr as a pending destination
//  rsv_addr   in   AW       register to reserve
//  rsv_ok     out  1        1 = a reserve this cycle is accepted
//  err        out  1        sticky error flag: underflow or overflow; cleared only by reset
// BEHAVIOUR
//  Reset
//  - All registers = 0, all counters = 0, err = 0.
//  - Reset overrides any same-cycle write or reserve.
//  Address 0
//  - Reads return 0; rd_pend = 0.
//  - Writes, releases and reserves to address 0 are ignored; rsv_ok = 1 for address 0.
//  Write
//  - A port hits when wrX_en && wrX_addr != 0.
//  - Array is updated at the next posedge.
//  - Both ports hit the same address: port 1 data is stored.
//  Read (combinational, zero latency)
//  - Priority: wr1 hit on the address -> wr1_data; else wr0 hit -> wr0_data; else array value.
//  Release
//  - Each write-port hit decrements that register's counter by 1.
//  - Both ports hitting the same address decrement it by 2.
//  Counter update
//  - cnt_eff = cnt - releases_this_cycle, floored at 0.
//  - cnt_next = cnt_eff + (rsv_en && rsv_ok && rsv_addr != 0).
//  - A release arriving when cnt == 0 (or the floor is hit) sets err; the counter stays at 0.
//  Reserve
//  - rsv_ok = (cnt_eff[rsv_addr] < 2**CNT_W-1).
//  - rsv_en while !rsv_ok: reserve ignored, err set; the requester must stall and retry.
//  Pending flag
//  - rd_pend[k] = (cnt_eff[rd_addr_k] != 0).
//  - A same-cycle reserve does not raise it; it becomes visible next cycle.
//  - Reserve and release on one register in the same cycle: net counter change 0, rd_pend reflects cnt_eff.
//  Trace (TRACE=1)
//  - One $display per stored write: "%d@%h: $%d <= %h" with $time, wrX_pc, addr, data.
//  - Same-address double write: only port 1 is printed; otherwise port 0 is printed first.
// STRUCTURE
//  - grf_pkg: default DW/NREG/AW, CNT_W, the trace format string, and a clog2 function.
//  - Sub-module grf_pend_cnt: one saturating up/down counter with release-count input,
//    cnt_eff/ok/underflow outputs; instantiated NREG-1 times by generate.
//  - Top level holds the data array, bypass muxes, err register and trace.
// TESTING
//  1 Reset, then read all ports at addr 0..31 -> rd_data = 0, rd_pend = 0, err = 0.
//  2 wr0 $5 <= 0x1234 while reading $5 on port 2 -> same-cycle rd_data = 0x1234; next cycle array = 0x1234, trace printed.
//  3 wr0 and wr1 both $7 (0xAAAA / 0xBBBB) -> bypass gives 0xBBBB and $7 holds 0xBBBB; one trace line, port 1.
//  4 Reserve $3 three times (CNT_W=2) -> rsv_ok 1,1,1 then 0;
//    a 4th reserve sets err; three releases -> rd_pend drops on the cycle of the 3rd release.
//  5 Reserve $9 and release $9 in the same cycle with cnt = 1 -> cnt stays 1, rd_pend = 1, err = 0.
//  6 Release $4 with cnt = 0 -> err = 1 next cycle and stays set;
//    assert reset mid-burst with writes pending -> all registers, counters and err = 0 next cycle.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared defaults for the scoreboarded general register file.
// Also holds the write-trace format and a constant clog2 helper.
package grf_pkg;

    function automatic int unsigned grf_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    localparam int unsigned GRF_DW    = 32;
    localparam int unsigned GRF_NREG  = 32;
    localparam int unsigned GRF_AW    = grf_clog2(GRF_NREG);
    localparam int unsigned GRF_CNT_W = 2;

    localparam string GRF_TRACE_FMT = "%d@%h: $%d <= %h";

endpackage

// File: rtl/grf_pend_cnt.sv
// Pending-writer counter for one register: releases first (floored at 0),
// then an accepted reserve increments the effective count.
module grf_pend_cnt
    import grf_pkg::*;
#(
    parameter int unsigned CNT_W = GRF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_rel,
    input  logic             i_rsv,
    output logic [CNT_W-1:0] o_cnt_eff,
    output logic             o_ok,
    output logic             o_underflow
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_inc;

    assign o_underflow = ({2'b00, r_cnt} < {{CNT_W{1'b0}}, i_rel});
    assign o_cnt_eff   = o_underflow ? '0 : (r_cnt - CNT_W'(i_rel));
    assign o_ok        = (o_cnt_eff != {CNT_W{1'b1}});
    assign w_inc       = i_rsv && o_ok;
    assign w_cnt_next  = o_cnt_eff + CNT_W'(w_inc);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/grf_scoreboard.sv
// General register file with two write ports, same-cycle read bypass and
// a per-register pending-writer scoreboard feeding the hazard logic.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int unsigned DW    = GRF_DW,
    parameter int unsigned NREG  = GRF_NREG,
    parameter int unsigned AW    = GRF_AW,
    parameter int unsigned NRD   = 3,
    parameter int unsigned CNT_W = GRF_CNT_W,
    parameter int unsigned TRACE = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD*DW-1:0] o_rd_data,
    output logic [NRD-1:0]    o_rd_pend,
    input  logic              i_wr0_en,
    input  logic [AW-1:0]     i_wr0_addr,
    input  logic [DW-1:0]     i_wr0_data,
    input  logic [31:0]       i_wr0_pc,
    input  logic              i_wr1_en,
    input  logic [AW-1:0]     i_wr1_addr,
    input  logic [DW-1:0]     i_wr1_data,
    input  logic [31:0]       i_wr1_pc,
    input  logic              i_rsv_en,
    input  logic [AW-1:0]     i_rsv_addr,
    output logic              o_rsv_ok,
    output logic              o_err
);

    logic [DW-1:0]    r_mem [NREG];
    logic             r_err;
    logic             w_hit0;
    logic             w_hit1;
    logic             w_same;
    logic             w_err_d;
    logic [CNT_W-1:0] w_cnt_eff [NREG];
    logic [NREG-1:0]  w_ok;
    logic [NREG-1:0]  w_uf;

    assign w_hit0 = i_wr0_en && (i_wr0_addr != '0);
    assign w_hit1 = i_wr1_en && (i_wr1_addr != '0);
    assign w_same = w_hit0 && w_hit1 && (i_wr0_addr == i_wr1_addr);

    // Register 0 has no counter: never pending, always reservable.
    assign w_cnt_eff[0] = '0;
    assign w_ok[0]      = 1'b1;
    assign w_uf[0]      = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        logic [1:0] w_rel;
        assign w_rel = {1'b0, w_hit0 && (i_wr0_addr == AW'(g))}
                     + {1'b0, w_hit1 && (i_wr1_addr == AW'(g))};
        grf_pend_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_rel      (w_rel),
            .i_rsv      (i_rsv_en && (i_rsv_addr == AW'(g))),
            .o_cnt_eff  (w_cnt_eff[g]),
            .o_ok       (w_ok[g]),
            .o_underflow(w_uf[g])
        );
    end

    assign o_rsv_ok = w_ok[i_rsv_addr];
    assign w_err_d  = r_err || (|w_uf) || (i_rsv_en && !o_rsv_ok);
    assign o_err    = r_err;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        assign w_ra = i_rd_addr[k*AW +: AW];
        assign o_rd_data[k*DW +: DW] =
            (w_hit1 && (i_wr1_addr == w_ra)) ? i_wr1_data :
            (w_hit0 && (i_wr0_addr == w_ra)) ? i_wr0_data : r_mem[w_ra];
        assign o_rd_pend[k] = (w_cnt_eff[w_ra] != '0);
    end

    // Port 1 is assigned last so it wins a same-address double write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_hit0) r_mem[i_wr0_addr] <= i_wr0_data;
            if (w_hit1) r_mem[i_wr1_addr] <= i_wr1_data;
            r_err <= w_err_d;
        end
    end

    if (TRACE != 0) begin : g_trace
`ifndef SYNTHESIS
        always_ff @(posedge i_clk) begin
            if (!i_reset) begin
                if (w_hit0 && !w_same) begin
                    $display(GRF_TRACE_FMT, $time, i_wr0_pc, i_wr0_addr, i_wr0_data);
                end
                if (w_hit1) begin
                    $display(GRF_TRACE_FMT, $time, i_wr1_pc, i_wr1_addr, i_wr1_data);
                end
            end
        end
`endif
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: bypass, double write, scoreboard
// reserve/release, sticky error and synchronous reset.
module tb_grf_scoreboard;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NRD  = 3;
    localparam int NREG = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_pend;
    logic              wr0_en, wr1_en, rsv_en;
    logic [AW-1:0]     wr0_addr, wr1_addr, rsv_addr;
    logic [DW-1:0]     wr0_data, wr1_data;
    logic [31:0]       wr0_pc, wr1_pc;
    logic              rsv_ok;
    logic              err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    grf_scoreboard #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (AW),
        .NRD  (NRD),
        .CNT_W(2),
        .TRACE(1)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data),
        .o_rd_pend (rd_pend),
        .i_wr0_en  (wr0_en),
        .i_wr0_addr(wr0_addr),
        .i_wr0_data(wr0_data),
        .i_wr0_pc  (wr0_pc),
        .i_wr1_en  (wr1_en),
        .i_wr1_addr(wr1_addr),
        .i_wr1_data(wr1_data),
        .i_wr1_pc  (wr1_pc),
        .i_rsv_en  (rsv_en),
        .i_rsv_addr(rsv_addr),
        .o_rsv_ok  (rsv_ok),
        .o_err     (err)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0; wr0_pc = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0; wr1_pc = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        rd_addr = '0;
    endtask

    task automatic rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rdd(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr0_en = 1'b1; wr0_addr = a; wr0_data = d; wr0_pc = 32'h100 + 32'(a);
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr1_en = 1'b1; wr1_addr = a; wr1_data = d; wr1_pc = 32'h200 + 32'(a);
    endtask

    task automatic rsv(input logic [AW-1:0] a);
        rsv_en = 1'b1; rsv_addr = a;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_err", err, 0);

        // 1: every address reads zero, nothing pending
        for (int a = 0; a < NREG; a++) begin
            for (int k = 0; k < NRD; k++) rd(k, AW'(a));
            #1;
            check("rst_data", rd_data, 0);
            check("rst_pend", rd_pend, 0);
        end
        tick();

        // 2: single write with same-cycle bypass on port 2
        idle(); wr0(5, 32'h1234); rd(2, 5); #1;
        check("byp_wr0", rdd(2), 32'h1234);
        check("byp_p0_addr0", rdd(0), 0);
        tick();
        idle(); rd(0, 5); #1;
        check("wr0_stored", rdd(0), 32'h1234);

        // 3: same-address double write, port 1 wins
        idle(); wr0(7, 32'hAAAA); wr1(7, 32'hBBBB); rd(0, 7); #1;
        check("dbl_byp", rdd(0), 32'hBBBB);
        tick();
        idle(); rd(1, 7); #1;
        check("dbl_stored", rdd(1), 32'hBBBB);
        idle(); wr0(8, 32'h1111); wr1(9, 32'h2222); rd(0, 8); rd(1, 9); rd(2, 0); #1;
        check("split_byp0", rdd(0), 32'h1111);
        check("split_byp1", rdd(1), 32'h2222);
        check("split_addr0", rdd(2), 0);
        tick();

        // 4: reserve $3 to saturation, overflow sets err, three releases
        idle(); rd(0, 3); rsv(3);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rsv_ok", rsv_ok, 1);
            check("rsv_pend", rd_pend[0], (i != 0));
            tick();
        end
        #1;
        check("rsv_full_ok", rsv_ok, 0);
        check("rsv_full_pend", rd_pend[0], 1);
        tick();
        rsv_en = 1'b0; #1;
        check("rsv_ovf_err", err, 1);
        for (int i = 0; i < 3; i++) begin
            wr0(3, 32'(i)); #1;
            check("rel_pend", rd_pend[0], (i != 2));
            tick();
        end
        idle(); rd(0, 3); #1;
        check("rel_done_pend", rd_pend[0], 0);
        check("err_sticky", err, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        check("rst_clr_err", err, 0);

        // reserve of $0 is always accepted and never pends
        idle(); rsv(0); rd(0, 0); #1;
        check("rsv0_ok", rsv_ok, 1);
        tick();
        idle(); #1;
        check("rsv0_err", err, 0);
        check("rsv0_pend", rd_pend[0], 0);

        // 5: reserve + release on the same register with cnt = 1
        rsv(9);
        tick();
        idle(); rsv(9); wr1(9, 32'h99); rd(0, 9); #1;
        check("rr_ok", rsv_ok, 1);
        check("rr_pend_now", rd_pend[0], 0);
        tick();
        idle(); rd(0, 9); #1;
        check("rr_pend_next", rd_pend[0], 1);
        check("rr_err", err, 0);
        check("rr_data", rdd(0), 32'h99);
        rsv(9);
        tick();
        idle(); wr0(9, 32'h1); wr1(9, 32'h2); rd(0, 9); #1;
        check("rel2_pend", rd_pend[0], 0);
        tick();
        idle(); rd(0, 9); #1;
        check("rel2_pend_next", rd_pend[0], 0);
        check("rel2_err", err, 0);

        // 6: release of an idle register, then reset mid-burst
        idle(); wr0(4, 32'h44);
        tick();
        idle(); #1;
        check("udf_err", err, 1);
        tick();
        check("udf_err_sticky", err, 1);
        wr0(10, 32'h55); rsv(11);
        tick();
        idle(); rd(0, 10); rd(1, 11); #1;
        check("pre_rst_data", rdd(0), 32'h55);
        check("pre_rst_pend", rd_pend[1], 1);
        reset = 1'b1; wr0(12, 32'h77); rsv(13);
        tick();
        reset = 1'b0;
        idle(); rd(0, 10); rd(1, 11); rd(2, 12); #1;
        check("mid_rst_data10", rdd(0), 0);
        check("mid_rst_pend11", rd_pend[1], 0);
        check("mid_rst_data12", rdd(2), 0);
        check("mid_rst_err", err, 0);
        rd(0, 13); #1;
        check("mid_rst_pend13", rd_pend[0], 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
